// File: rtl/det_seq_ctrl.sv
// Determinant sequencer for signed 2x2/3x3 matrices. It time-shares one external
// DATA_W x DATA_W multiplier and accumulates with DATA_W-bit wrap-around.
module det_seq_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       tamanho,
  input  logic [9*DATA_W-1:0]        matriz,
  output logic signed [DATA_W-1:0]   mult_a,
  output logic signed [DATA_W-1:0]   mult_b,
  input  logic signed [DATA_W-1:0]   mult_resultado,
  input  logic                       mult_overflow,
  output logic                       busy,
  output logic                       done,
  output logic signed [DATA_W-1:0]   resultado,
  output logic                       flag_overflow
);

  typedef enum logic [1:0] {IDLE, CALC, FIM} state_t;
  typedef enum logic [2:0] {
    K_LOAD_P,    // P   = prod
    K_LOAD_T,    // T   = P - prod
    K_LOAD_ACC,  // ACC = prod
    K_ACC_SUB,   // ACC = ACC - prod
    K_ACC_ADD,   // ACC = ACC + prod
    K_ACC_PSUB   // ACC = P - prod (2x2 closing step)
  } kind_t;

  state_t                     state_q, state_nxt;
  logic [3:0]                 step_q;
  logic [9*DATA_W-1:0]        mat_q;
  logic                       size_q;
  logic signed [DATA_W-1:0]   p_q, t_q, acc_q;
  logic                       sticky_q;

  kind_t                      kind;
  logic                       last;
  logic signed [DATA_W-1:0]   alu_res;
  logic                       alu_ovf;
  logic signed [DATA_W-1:0]   el [9];

  function automatic logic add_ovf(input logic signed [DATA_W-1:0] x,
                                   input logic signed [DATA_W-1:0] y,
                                   input logic signed [DATA_W-1:0] s);
    return (x[DATA_W-1] == y[DATA_W-1]) && (s[DATA_W-1] != x[DATA_W-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [DATA_W-1:0] x,
                                   input logic signed [DATA_W-1:0] y,
                                   input logic signed [DATA_W-1:0] d);
    return (x[DATA_W-1] != y[DATA_W-1]) && (d[DATA_W-1] != x[DATA_W-1]);
  endfunction

  for (genvar k = 0; k < 9; k++) begin : g_el
    assign el[k] = $signed(mat_q[DATA_W*k +: DATA_W]);
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == FIM);

  // Operand/step decode: 3x3 expands along row 0 using the three 2x2 cofactors.
  always_comb begin
    state_nxt = state_q;
    mult_a    = '0;
    mult_b    = '0;
    kind      = K_LOAD_P;
    last      = 1'b0;
    case (state_q)
      IDLE: if (start) state_nxt = CALC;
      CALC: begin
        if (size_q) begin
          case (step_q)
            4'd0: begin mult_a = el[4]; mult_b = el[8]; kind = K_LOAD_P;   end
            4'd1: begin mult_a = el[5]; mult_b = el[7]; kind = K_LOAD_T;   end
            4'd2: begin mult_a = el[0]; mult_b = t_q;   kind = K_LOAD_ACC; end
            4'd3: begin mult_a = el[3]; mult_b = el[8]; kind = K_LOAD_P;   end
            4'd4: begin mult_a = el[5]; mult_b = el[6]; kind = K_LOAD_T;   end
            4'd5: begin mult_a = el[1]; mult_b = t_q;   kind = K_ACC_SUB;  end
            4'd6: begin mult_a = el[3]; mult_b = el[7]; kind = K_LOAD_P;   end
            4'd7: begin mult_a = el[4]; mult_b = el[6]; kind = K_LOAD_T;   end
            4'd8: begin mult_a = el[2]; mult_b = t_q;   kind = K_ACC_ADD;  last = 1'b1; end
            default: ;
          endcase
        end else if (!step_q[0]) begin
          mult_a = el[0]; mult_b = el[4]; kind = K_LOAD_P;
        end else begin
          mult_a = el[1]; mult_b = el[3]; kind = K_ACC_PSUB; last = 1'b1;
        end
        if (last) state_nxt = FIM;
      end
      FIM:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_res = mult_resultado;
    alu_ovf = 1'b0;
    case (kind)
      K_LOAD_T: begin
        alu_res = p_q - mult_resultado;
        alu_ovf = sub_ovf(p_q, mult_resultado, alu_res);
      end
      K_ACC_SUB: begin
        alu_res = acc_q - mult_resultado;
        alu_ovf = sub_ovf(acc_q, mult_resultado, alu_res);
      end
      K_ACC_ADD: begin
        alu_res = acc_q + mult_resultado;
        alu_ovf = add_ovf(acc_q, mult_resultado, alu_res);
      end
      K_ACC_PSUB: begin
        alu_res = p_q - mult_resultado;
        alu_ovf = sub_ovf(p_q, mult_resultado, alu_res);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      step_q        <= '0;
      mat_q         <= '0;
      size_q        <= 1'b0;
      p_q           <= '0;
      t_q           <= '0;
      acc_q         <= '0;
      sticky_q      <= 1'b0;
      resultado     <= '0;
      flag_overflow <= 1'b0;
    end else begin
      state_q <= state_nxt;
      case (state_q)
        IDLE: if (start) begin
          mat_q    <= matriz;
          size_q   <= tamanho;
          sticky_q <= 1'b0;
          step_q   <= '0;
        end
        CALC: begin
          step_q   <= step_q + 4'd1;
          sticky_q <= sticky_q | mult_overflow | alu_ovf;
          case (kind)
            K_LOAD_P: p_q   <= alu_res;
            K_LOAD_T: t_q   <= alu_res;
            default:  acc_q <= alu_res;
          endcase
          // Results only move on the last step so they hold through CALC.
          if (last) begin
            resultado     <= alu_res;
            flag_overflow <= sticky_q | mult_overflow | alu_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
